// File: rtl/game_pkg.sv
// game_pkg: play-area geometry, coordinate widths, sequencer states and fixed positions
// shared by the game controller, its interface and the food LFSR.
package game_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    localparam int X_MIN     = 11;
    localparam int X_MAX     = 1428;
    localparam int Y_MIN     = 11;
    localparam int Y_MAX     = 888;
    localparam int FOOD_HALF = 8;

    localparam logic [15:0]    LFSR_SEED    = 16'hACE1;
    localparam logic [X_W-1:0] CHAR_RESET_X = 11'd720;
    localparam logic [Y_W-1:0] CHAR_RESET_Y = 10'd450;
    localparam logic [X_W-1:0] FOOD_RESET_X = 11'd200;
    localparam logic [Y_W-1:0] FOOD_RESET_Y = 10'd200;
    localparam logic [X_W-1:0] FALLBACK_X   = 11'd720;
    localparam logic [Y_W-1:0] FALLBACK_Y   = 10'd450;
    localparam logic [X_W-1:0] ALT_FOOD_X   = 11'd80;
    localparam logic [Y_W-1:0] ALT_FOOD_Y   = 10'd80;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        CHECK,
        EAT,
        RELOCATE
    } state_e;

    // Two boxes touch when both centre distances are strictly below the combined reach.
    function automatic logic overlaps(input logic [X_W-1:0] ax, input logic [Y_W-1:0] ay,
                                      input logic [X_W-1:0] bx, input logic [Y_W-1:0] by,
                                      input logic [11:0] reach);
        logic [11:0] dx;
        logic [11:0] dy;
        dx = (ax > bx) ? 12'(ax - bx) : 12'(bx - ax);
        dy = (ay > by) ? 12'(ay - by) : 12'(by - ay);
        return (dx < reach) && (dy < reach);
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: frame tick and buttons into the sequencer, registered game state out to the compositor.
interface game_ctrl_if;
    import game_pkg::*;

    logic           frame_tick;
    logic           btn_up;
    logic           btn_down;
    logic           btn_left;
    logic           btn_right;
    logic [X_W-1:0] characterPos_x;
    logic [Y_W-1:0] characterPos_y;
    logic [X_W-1:0] foodPos_x;
    logic [Y_W-1:0] foodPos_y;
    logic [7:0]     characterSize;
    logic [15:0]    score;
    logic           eat_pulse;
    logic           busy;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right,
        input  characterPos_x, characterPos_y, foodPos_x, foodPos_y,
               characterSize, score, eat_pulse, busy
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right,
        output characterPos_x, characterPos_y, foodPos_x, foodPos_y,
               characterSize, score, eat_pulse, busy
    );

endinterface

// File: rtl/food_lfsr.sv
// food_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that seeds food placement.
module food_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: per-frame sequencer that moves the character, detects eats and relocates the food.
// Defining GAME_CTRL_WRAP_EN makes the character wrap at the play-area edges instead of clamping.
module game_ctrl
    import game_pkg::*;
#(
    parameter int STEP      = 4,
    parameter int SIZE_INIT = 16,
    parameter int SIZE_GROW = 4,
    parameter int SIZE_MAX  = 128,
    parameter int MAX_TRIES = 64
) (
    input logic        clk,
    input logic        rst_n,
    game_ctrl_if.slave gc
);

    localparam int                TRY_W     = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic signed [11:0] STEP_S   = 12'(STEP);
    localparam logic [X_W-1:0]    CAND_X_LO = X_W'(X_MIN + FOOD_HALF);
    localparam logic [X_W-1:0]    CAND_X_HI = X_W'(X_MAX - FOOD_HALF);
    localparam logic [Y_W-1:0]    CAND_Y_LO = Y_W'(Y_MIN + FOOD_HALF);
    localparam logic [Y_W-1:0]    CAND_Y_HI = Y_W'(Y_MAX - FOOD_HALF);

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic [X_W-1:0]    charX_q, charX_d, foodX_q, foodX_d;
    logic [Y_W-1:0]    charY_q, charY_d, foodY_q, foodY_d;
    logic [7:0]        size_q, size_d;
    logic [15:0]       score_q, score_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic              eatPulse_q, busy_q;
    logic [15:0]       lfsr;

    logic signed [11:0] halfS, posS, newS, loS, hiS, resS;
    logic [11:0]        reach;
    logic               moveAny, moveOnX, charHit, candOk, fbHit;
    logic [X_W-1:0]     candX;
    logic [Y_W-1:0]     candY;
    logic [8:0]         grownSize;

    food_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr)
    );

    // Only one axis moves per frame: vertical buttons win, then left over right.
    always_comb begin
        halfS   = 12'(size_q[7:1]);
        reach   = 12'(size_q[7:1]) + 12'(FOOD_HALF);
        moveAny = gc.btn_up || gc.btn_down || gc.btn_left || gc.btn_right;
        moveOnX = !(gc.btn_up || gc.btn_down);
        posS    = moveOnX ? 12'(charX_q) : 12'(charY_q);
        loS     = (moveOnX ? 12'(X_MIN) : 12'(Y_MIN)) + halfS;
        hiS     = (moveOnX ? 12'(X_MAX) : 12'(Y_MAX)) - halfS;
        newS    = (gc.btn_up || (moveOnX && gc.btn_left)) ? posS - STEP_S : posS + STEP_S;
        resS    = newS;
`ifdef GAME_CTRL_WRAP_EN
        if (newS < loS) begin
            resS = hiS;
        end else if (newS > hiS) begin
            resS = loS;
        end
`else
        if (newS < loS) begin
            resS = loS;
        end else if (newS > hiS) begin
            resS = hiS;
        end
`endif
        candX     = lfsr[10:0];
        candY     = lfsr[15:6];
        charHit   = overlaps(charX_q, charY_q, foodX_q, foodY_q, reach);
        candOk    = (candX >= CAND_X_LO) && (candX <= CAND_X_HI) &&
                    (candY >= CAND_Y_LO) && (candY <= CAND_Y_HI) &&
                    !overlaps(charX_q, charY_q, candX, candY, reach);
        fbHit     = overlaps(charX_q, charY_q, FALLBACK_X, FALLBACK_Y, reach);
        grownSize = 9'(size_q) + 9'(SIZE_GROW);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        charX_d   = charX_q;
        charY_d   = charY_q;
        foodX_d   = foodX_q;
        foodY_d   = foodY_q;
        size_d    = size_q;
        score_d   = score_q;
        tries_d   = tries_q;
        case (state_q)
            IDLE: begin
                if (gc.frame_tick || pending_q) begin
                    pending_d = 1'b0;
                    state_d   = MOVE;
                end
            end
            MOVE: begin
                if (moveAny) begin
                    if (moveOnX) begin
                        charX_d = resS[X_W-1:0];
                    end else begin
                        charY_d = resS[Y_W-1:0];
                    end
                end
                state_d = CHECK;
            end
            CHECK: begin
                state_d = charHit ? EAT : IDLE;
            end
            EAT: begin
                score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
                size_d  = (grownSize > 9'(SIZE_MAX)) ? 8'(SIZE_MAX) : grownSize[7:0];
                tries_d = '0;
                state_d = RELOCATE;
            end
            RELOCATE: begin
                if (candOk) begin
                    foodX_d = candX;
                    foodY_d = candY;
                    state_d = IDLE;
                end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    foodX_d = fbHit ? ALT_FOOD_X : FALLBACK_X;
                    foodY_d = fbHit ? ALT_FOOD_Y : FALLBACK_Y;
                    state_d = IDLE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Ticks that land while a sequence is running collapse into one deferred frame.
        if ((state_q != IDLE) && gc.frame_tick) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            charX_q    <= CHAR_RESET_X;
            charY_q    <= CHAR_RESET_Y;
            foodX_q    <= FOOD_RESET_X;
            foodY_q    <= FOOD_RESET_Y;
            size_q     <= 8'(SIZE_INIT);
            score_q    <= '0;
            tries_q    <= '0;
            eatPulse_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            charX_q    <= charX_d;
            charY_q    <= charY_d;
            foodX_q    <= foodX_d;
            foodY_q    <= foodY_d;
            size_q     <= size_d;
            score_q    <= score_d;
            tries_q    <= tries_d;
            eatPulse_q <= (state_d == EAT);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign gc.characterPos_x = charX_q;
    assign gc.characterPos_y = charY_q;
    assign gc.foodPos_x      = foodX_q;
    assign gc.foodPos_y      = foodY_q;
    assign gc.characterSize  = size_q;
    assign gc.score          = score_q;
    assign gc.eat_pulse      = eatPulse_q;
    assign gc.busy           = busy_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: drives frames with chasing and random buttons and compares every frame
// against a frame-level model of movement, eating and food relocation.
module tb_game_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    game_ctrl_if gc();

    game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .gc    (gc)
    );

    int compared   = 0;
    int mismatched = 0;

    int mX, mY, mFx, mFy, mSize, mScore;
    logic [15:0] refLfsr;

    // Free-running reference sequence so the model knows the LFSR value at any frame start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) refLfsr <= 16'hACE1;
        else        refLfsr <= lfsrStep(refLfsr);
    end

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit hits(input int ax, input int ay, input int bx, input int by, input int half);
        return (absInt(ax - bx) < half + 8) && (absInt(ay - by) < half + 8);
    endfunction

    function automatic int moveAxis(input int pos, input int delta, input int lo, input int hi);
        int v;
        v = pos + delta;
`ifdef GAME_CTRL_WRAP_EN
        if (v < lo) return hi;
        if (v > hi) return lo;
`else
        if (v < lo) return lo;
        if (v > hi) return hi;
`endif
        return v;
    endfunction

    function automatic logic [3:0] chaseButtons();
        int dx, dy;
        dx = mFx - mX;
        dy = mFy - mY;
        if (absInt(dx) >= absInt(dy)) return (dx > 0) ? 4'b0001 : 4'b0010;
        return (dy > 0) ? 4'b0100 : 4'b1000;
    endfunction

    task automatic resetModel();
        mX = 720; mY = 450; mFx = 200; mFy = 200; mSize = 16; mScore = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkReset(input string pre);
        checkOutput({pre, "CharX"}, 32'(gc.characterPos_x), 32'd720);
        checkOutput({pre, "CharY"}, 32'(gc.characterPos_y), 32'd450);
        checkOutput({pre, "FoodX"}, 32'(gc.foodPos_x), 32'd200);
        checkOutput({pre, "FoodY"}, 32'(gc.foodPos_y), 32'd200);
        checkOutput({pre, "Size"}, 32'(gc.characterSize), 32'd16);
        checkOutput({pre, "Score"}, 32'(gc.score), 32'd0);
        checkOutput({pre, "EatPulse"}, 32'(gc.eat_pulse), 32'd0);
        checkOutput({pre, "Busy"}, 32'(gc.busy), 32'd0);
    endtask

    // b = {up, down, left, right}; frame outcome predicted from the rules, expBusy = busy cycles.
    task automatic modelFrame(input logic [15:0] l0, input logic [3:0] b,
                              output int expBusy, output bit expEat);
        int half, tries, cx, cy;
        logic [15:0] l;
        bit placed;
        half = mSize / 2;
        if (b[3])      mY = moveAxis(mY, -4, 11 + half, 888 - half);
        else if (b[2]) mY = moveAxis(mY, 4, 11 + half, 888 - half);
        else if (b[1]) mX = moveAxis(mX, -4, 11 + half, 1428 - half);
        else if (b[0]) mX = moveAxis(mX, 4, 11 + half, 1428 - half);
        expEat  = hits(mX, mY, mFx, mFy, half);
        expBusy = 2;
        if (expEat) begin
            if (mScore < 65535) mScore++;
            mSize = (mSize + 4 > 128) ? 128 : mSize + 4;
            half  = mSize / 2;
            l = l0;
            repeat (4) l = lfsrStep(l);
            placed = 1'b0;
            tries  = 64;
            for (int j = 0; j < 64 && !placed; j++) begin
                cx = int'(l[10:0]);
                cy = int'(l[15:6]);
                if (cx >= 19 && cx <= 1420 && cy >= 19 && cy <= 880 && !hits(mX, mY, cx, cy, half)) begin
                    mFx = cx; mFy = cy; placed = 1'b1; tries = j + 1;
                end
                l = lfsrStep(l);
            end
            if (!placed) begin
                if (hits(mX, mY, 720, 450, half)) begin mFx = 80; mFy = 80; end
                else begin mFx = 720; mFy = 450; end
            end
            expBusy = 3 + tries;
        end
    endtask

    // Runs one frame from an idle negedge and ends on the negedge where busy is seen low.
    task automatic applyStimulus(input logic [3:0] b, input bit driveTick, input bit dbl,
                                 input bit rstMid, output bit wasDbl, output bit aborted);
        int oldX, oldY, expBusy, busyCnt, eats;
        bit expEat, done, injDbl;
        {gc.btn_up, gc.btn_down, gc.btn_left, gc.btn_right} = b;
        oldX = mX;
        oldY = mY;
        modelFrame(refLfsr, b, expBusy, expEat);
        injDbl  = dbl && expEat && (expBusy >= 5);
        wasDbl  = injDbl;
        aborted = 1'b0;
        if (driveTick) gc.frame_tick = 1'b1;
        busyCnt = 0;
        eats    = 0;
        done    = 1'b0;
        for (int i = 1; i <= 100 && !done; i++) begin
            @(negedge clk);
            gc.frame_tick = injDbl && (i == 4 || i == 5);
            if (rstMid && expEat && i == 4) begin
                rst_n = 1'b0;
                #1;
                checkReset("midRst");
                resetModel();
                @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1'b1;
                done    = 1'b1;
            end else begin
                if (i == 1) begin
                    checkOutput("holdX", 32'(gc.characterPos_x), 32'(oldX));
                    checkOutput("holdY", 32'(gc.characterPos_y), 32'(oldY));
                end
                if (i == 2) begin
                    checkOutput("movedX", 32'(gc.characterPos_x), 32'(mX));
                    checkOutput("movedY", 32'(gc.characterPos_y), 32'(mY));
                end
                if (gc.busy === 1'b1) busyCnt++;
                else done = 1'b1;
                if (gc.eat_pulse === 1'b1) eats++;
            end
        end
        gc.frame_tick = 1'b0;
        if (aborted) return;
        checkOutput("busyCycles", 32'(busyCnt), 32'(expBusy));
        checkOutput("eatPulses", 32'(eats), 32'(expEat));
        checkOutput("charX", 32'(gc.characterPos_x), 32'(mX));
        checkOutput("charY", 32'(gc.characterPos_y), 32'(mY));
        checkOutput("foodX", 32'(gc.foodPos_x), 32'(mFx));
        checkOutput("foodY", 32'(gc.foodPos_y), 32'(mFy));
        checkOutput("size", 32'(gc.characterSize), 32'(mSize));
        checkOutput("score", 32'(gc.score), 32'(mScore));
    endtask

    initial begin
        #950000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard, quiet;
        logic [3:0] b;
        bit wasDbl, aborted, dbl, unused;

        gc.frame_tick = 1'b0;
        gc.btn_up     = 1'b0;
        gc.btn_down   = 1'b0;
        gc.btn_left   = 1'b0;
        gc.btn_right  = 1'b0;
        rst_n         = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        checkReset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, wasDbl, aborted);
        checkOutput("firstMoveX", 32'(gc.characterPos_x), 32'd724);
        checkOutput("firstMoveY", 32'(gc.characterPos_y), 32'd450);
        checkOutput("firstScore", 32'(gc.score), 32'd0);

        guard = 0;
        while (mX < 1416 && guard < 400) begin
            applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, wasDbl, aborted);
            guard++;
        end
        checkOutput("reachX", 32'(gc.characterPos_x), 32'd1416);
        repeat (3) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, wasDbl, aborted);
`ifdef GAME_CTRL_WRAP_EN
        checkOutput("edgeX", 32'(gc.characterPos_x), 32'd23);
`else
        checkOutput("edgeX", 32'(gc.characterPos_x), 32'd1420);
`endif

        guard = 0;
        while (mScore < 40 && guard < 16000) begin
            if ($urandom_range(0, 7) == 0) b = 4'($urandom_range(0, 15));
            else b = chaseButtons();
            dbl = (mScore < 38) && ($urandom_range(0, 1) == 1);
            applyStimulus(b, 1'b1, dbl, 1'b0, wasDbl, aborted);
            if (wasDbl) begin
                applyStimulus(b, 1'b0, 1'b0, 1'b0, unused, aborted);
                quiet = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (gc.busy !== 1'b0) quiet++;
                end
                checkOutput("pendingCollapsed", 32'(quiet), 32'd0);
            end
            guard++;
        end
        checkOutput("score40", 32'(gc.score), 32'd40);
        checkOutput("sizeMax", 32'(gc.characterSize), 32'd128);

        aborted = 1'b0;
        guard   = 0;
        while (!aborted && guard < 4000) begin
            applyStimulus(chaseButtons(), 1'b1, 1'b0, 1'b1, wasDbl, aborted);
            guard++;
        end
        checkOutput("resetReached", 32'(aborted), 32'd1);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, wasDbl, aborted);
        checkOutput("postRstX", 32'(gc.characterPos_x), 32'd724);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Per-frame game sequencer that owns the character and food state consumed by the pixel compositor (draw_con).
- On each frame tick it moves the character from the button inputs and clamps it to the play area.
- It then detects a character/food overlap, grows the character, counts score, and relocates the food with an LFSR.
- Outputs are stable registers that change only during vertical blank.

Parameters:
- STEP, 4: pixels moved per frame.
- SIZE_INIT, 16: characterSize after reset.
- SIZE_GROW, 4: size increment per eat.
- SIZE_MAX, 128: size saturation value.
- X_MIN, 11 / X_MAX, 1428: play-area x bounds, inclusive.
- Y_MIN, 11 / Y_MAX, 888: play-area y bounds, inclusive.
- FOOD_HALF, 8: food half-width.
- MAX_TRIES, 64: relocation attempts before fallback.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at the start of vertical blank
- btn_up, btn_down, btn_left, btn_right  in  1 each  synchronised, level-sensitive direction buttons
- characterPos_x  out  11  character centre x
- characterPos_y  out  10  character centre y
- foodPos_x  out  11  food centre x
- foodPos_y  out  10  food centre y
- characterSize  out  8  character full width
- score  out  16  eat count
- eat_pulse  out  1  one-cycle pulse per eat
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - characterPos = (720,450); foodPos = (200,200).
  - characterSize = SIZE_INIT; score = 0; eat_pulse = 0; busy = 0.
  - state = IDLE; LFSR = 16'hACE1; pending = 0.
  - Reset mid-sequence aborts immediately to these values.
- FSM: IDLE -> MOVE -> CHECK -> (EAT -> RELOCATE ->) IDLE.
  - IDLE: on frame_tick or pending, clear pending and go to MOVE.
  - MOVE (1 cycle): direction priority up > down > left > right; only one axis moves per frame; no button held means no move.
    - Arithmetic is 12-bit signed; half = characterSize>>1.
    - new = pos ± STEP, clamped to [MIN+half, MAX-half] on the moving axis.
    - Updated position is visible 2 cycles after frame_tick (tick registered in IDLE, written in MOVE).
  - CHECK (1 cycle): overlap when |cx-fx| < half+FOOD_HALF AND |cy-fy| < half+FOOD_HALF, using strict inequality and the post-move position.
    - Overlap goes to EAT; otherwise goes to IDLE.
  - EAT (1 cycle):
    - eat_pulse = 1.
    - score +1, saturating at 16'hFFFF.
    - characterSize = min(size+SIZE_GROW, SIZE_MAX).
  - RELOCATE (one attempt per cycle):
    - Candidate x = lfsr[10:0], candidate y = lfsr[15:6].
    - Accept when x is in [X_MIN+FOOD_HALF, X_MAX-FOOD_HALF], y is in [Y_MIN+FOOD_HALF, Y_MAX-FOOD_HALF], and the candidate does not overlap the post-eat character.
    - On accept, write foodPos and go to IDLE.
    - After MAX_TRIES rejections, fall back to (720,450); if that overlaps the character, use (80,80). Go to IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk cycle in all states.
- frame_tick while busy sets pending. Multiple ticks collapse to one, which is serviced on return to IDLE.
- Outputs hold their values outside MOVE/EAT/RELOCATE writes; no combinational path from inputs to outputs.
- Worst-case sequence is 3+MAX_TRIES cycles, far below vertical-blank length.

Optional Feature:
- Macro: GAME_CTRL_WRAP_EN.
- Defined: MOVE wraps instead of clamping. Leaving past MIN+half places the character at MAX-half; leaving past MAX-half places it at MIN+half.
- Undefined: the clamp behaviour described under Behaviour.

Decomposition:
- Package game_pkg:
  - play-area bounds and FOOD_HALF;
  - coordinate width constants (X_W=11, Y_W=10);
  - FSM state enum (IDLE, MOVE, CHECK, EAT, RELOCATE);
  - reset positions and fallback positions.
- Sub-module food_lfsr: free-running 16-bit LFSR with async active-low reset to the seed; exposes the current value.

Test Plan:
- Reset then frame_tick with btn_right held -> characterPos_x = 724 two cycles after the tick; y = 450; score = 0.
- Char at x = 1416 with size 16, hold btn_right for 3 ticks -> x saturates at 1420 (1428-8).
  - With GAME_CTRL_WRAP_EN defined, x = 19 on the wrapping frame.
- Place food at (728,450), char at (720,450) size 16, single tick with no buttons -> eat_pulse once, score = 1, size = 20.
  - New foodPos is in range and non-overlapping; busy drops within 67 cycles.
- Eat 40 times -> characterSize = 128 and stays 128; score = 40.
- Assert frame_tick twice while in RELOCATE -> exactly one extra MOVE after IDLE.
- Assert rst_n low during RELOCATE -> all outputs at reset values asynchronously; state IDLE after release.
